// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI memory model.
package idli_pkg;

  // One 4-bit SQI bus nibble.
  typedef logic [3:0] slice_t;

  localparam logic [7:0]  SQI_CMD_READ     = 8'h03;
  localparam logic [7:0]  SQI_CMD_WRITE    = 8'h02;
  localparam int unsigned SQI_ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    READ,
    WRITE,
    IGNORE
  } sqi_state_t;

endpackage

// File: rtl/idli_sqi_ram_m.sv
// Byte array for the SQI SRAM model: one synchronous write port shared by
// the serial frontdoor and the backdoor (frontdoor wins on the same byte),
// plus asynchronous read ports for the serialiser and the backdoor.
module idli_sqi_ram_m #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              fd_wr,
  input  logic [ADDR_W-1:0] fd_addr,
  input  logic [7:0]        fd_wdata,
  input  logic              bd_wr,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [7:0]        bd_rdata
);

  logic [7:0] mem [0:(1 << ADDR_W) - 1];

  // Array writes; a backdoor write to the byte the frontdoor hits is dropped.
  always_ff @(posedge clk) begin
    if (fd_wr) begin
      mem[fd_addr] <= fd_wdata;
    end
    if (bd_wr && !(fd_wr && (fd_addr == bd_addr))) begin
      mem[bd_addr] <= bd_wdata;
    end
  end

  assign rd_data  = mem[rd_addr];
  assign bd_rdata = mem[bd_addr];

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI serial SRAM model: command/address/dummy/data FSM with sequential
// auto-increment, driving a byte array with a bench backdoor.
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int unsigned ADDR_W        = 17,
  parameter int unsigned DUMMY_NIBBLES = 2
) (
  input  logic              i_mem_gck,
  input  logic              i_mem_rst,
  input  logic              i_mem_sck,
  input  logic              i_mem_cs,
  input  slice_t            i_mem_sio,
  output slice_t            o_mem_sio,
  output logic              o_mem_sio_en,
  input  logic              i_mem_bd_wr,
  input  logic [ADDR_W-1:0] i_mem_bd_addr,
  input  logic [7:0]        i_mem_bd_wdata,
  output logic [7:0]        o_mem_bd_rdata
);

  localparam logic [7:0] ADDR_LAST  = 8'(SQI_ADDR_NIBBLES - 1);
  localparam logic [7:0] DUMMY_LAST = (DUMMY_NIBBLES == 0) ? 8'd0 : 8'(DUMMY_NIBBLES - 1);

  sqi_state_t        state;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] addr;
  slice_t            hold;     // command high nibble, later write-data high nibble
  logic              is_read;
  logic              phase;    // 0: high nibble of the current byte, 1: low nibble

  logic              slot;
  logic [ADDR_W-1:0] addr_shift;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              fd_wr;
  logic [7:0]        fd_wdata;

  assign slot       = !i_mem_cs && i_mem_sck;
  assign addr_shift = ADDR_W'({addr, i_mem_sio});
  assign addr_inc   = addr + ADDR_W'(1);
  assign fd_wr      = slot && (state == WRITE) && phase;
  assign fd_wdata   = {hold, i_mem_sio};

  // Serialiser read address: the byte whose nibble is loaded at the end of this slot.
  // In ADDR the final address nibble is still on the bus, so use the shifted value.
  always_comb begin
    rd_addr = addr;
    if (state == ADDR) begin
      rd_addr = addr_shift;
    end else if ((state == READ) && phase) begin
      rd_addr = addr_inc;
    end
  end

  // Protocol FSM with registered read-data outputs.
  always_ff @(posedge i_mem_gck or posedge i_mem_rst) begin
    if (i_mem_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr         <= '0;
      hold         <= '0;
      is_read      <= 1'b0;
      phase        <= 1'b0;
      o_mem_sio    <= '0;
      o_mem_sio_en <= 1'b0;
    end else if (i_mem_cs) begin
      state        <= IDLE;
      cnt          <= '0;
      phase        <= 1'b0;
      o_mem_sio    <= '0;
      o_mem_sio_en <= 1'b0;
    end else if (i_mem_sck) begin
      case (state)
        IDLE: begin
          hold  <= i_mem_sio;
          state <= CMD;
        end
        CMD: begin
          cnt <= '0;
          if ({hold, i_mem_sio} == SQI_CMD_READ) begin
            is_read <= 1'b1;
            state   <= ADDR;
          end else if ({hold, i_mem_sio} == SQI_CMD_WRITE) begin
            is_read <= 1'b0;
            state   <= ADDR;
          end else begin
            state <= IGNORE;
          end
        end
        ADDR: begin
          addr <= addr_shift;
          if (cnt == ADDR_LAST) begin
            cnt   <= '0;
            phase <= 1'b0;
            if (!is_read) begin
              state <= WRITE;
            end else if (DUMMY_NIBBLES == 0) begin
              state        <= READ;
              o_mem_sio    <= rd_data[7:4];
              o_mem_sio_en <= 1'b1;
            end else begin
              state <= DUMMY;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DUMMY: begin
          if (cnt == DUMMY_LAST) begin
            cnt          <= '0;
            state        <= READ;
            o_mem_sio    <= rd_data[7:4];
            o_mem_sio_en <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        READ: begin
          phase <= !phase;
          if (!phase) begin
            o_mem_sio <= rd_data[3:0];
          end else begin
            addr      <= addr_inc;
            o_mem_sio <= rd_data[7:4];
          end
        end
        WRITE: begin
          phase <= !phase;
          if (!phase) begin
            hold <= i_mem_sio;
          end else begin
            addr <= addr_inc;
          end
        end
        IGNORE: begin
          o_mem_sio    <= '0;
          o_mem_sio_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  idli_sqi_ram_m #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (i_mem_gck),
    .fd_wr    (fd_wr),
    .fd_addr  (addr),
    .fd_wdata (fd_wdata),
    .bd_wr    (i_mem_bd_wr),
    .bd_addr  (i_mem_bd_addr),
    .bd_wdata (i_mem_bd_wdata),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .bd_rdata (o_mem_bd_rdata)
  );

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for the SQI SRAM model: table-driven read/stall sequence
// plus hand-written write, wrap, abort, bad-command, collision and reset cases.
`timescale 1ns/1ps
module tb_idli_sqi_mem_m;

  logic        gck = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        cs  = 1'b1;
  logic [3:0]  sio_in = '0;
  logic [3:0]  sio_out;
  logic        sio_en;
  logic        bd_wr = 1'b0;
  logic [16:0] bd_addr = '0;
  logic [7:0]  bd_wdata = '0;
  logic [7:0]  bd_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       cs;
    logic       sck;
    logic [3:0] sio;
    logic [3:0] exp_sio;
    logic       exp_en;
  } vec_t;

  vec_t tbl[$];

  idli_sqi_mem_m #(
    .ADDR_W        (17),
    .DUMMY_NIBBLES (2)
  ) dut (
    .i_mem_gck      (gck),
    .i_mem_rst      (rst),
    .i_mem_sck      (sck),
    .i_mem_cs       (cs),
    .i_mem_sio      (sio_in),
    .o_mem_sio      (sio_out),
    .o_mem_sio_en   (sio_en),
    .i_mem_bd_wr    (bd_wr),
    .i_mem_bd_addr  (bd_addr),
    .i_mem_bd_wdata (bd_wdata),
    .o_mem_bd_rdata (bd_rdata)
  );

  always #5 gck = ~gck;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One gck edge with the given bus values; returns 1ns after the edge.
  task automatic cyc(input logic c, input logic s, input logic [3:0] n);
    @(negedge gck);
    cs     = c;
    sck    = s;
    sio_in = n;
    @(posedge gck);
    #1;
  endtask

  task automatic slot(input logic [3:0] n);
    cyc(1'b0, 1'b1, n);
  endtask

  task automatic deselect();
    cyc(1'b1, 1'b0, 4'h0);
  endtask

  task automatic check_out(input string nm, input logic en, input logic [3:0] s);
    check(nm, {3'b000, sio_en, sio_out}, {3'b000, en, s});
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    slot(cmd[7:4]);
    slot(cmd[3:0]);
    for (int i = 0; i < 6; i++) slot(a[23 - 4*i -: 4]);
  endtask

  task automatic bd_write(input logic [16:0] a, input logic [7:0] d);
    @(negedge gck);
    bd_wr    = 1'b1;
    bd_addr  = a;
    bd_wdata = d;
    @(posedge gck);
    #1;
    bd_wr = 1'b0;
  endtask

  task automatic bd_check(input string nm, input logic [16:0] a, input logic [7:0] exp);
    bd_addr = a;
    #1;
    check(nm, bd_rdata, exp);
  endtask

  // Write n (1..3) bytes, MSB-first in d, starting at a.
  task automatic do_write(input logic [23:0] a, input logic [23:0] d, input int n);
    send_hdr(8'h02, a);
    for (int b = 0; b < n; b++) begin
      slot(d[23 - 8*b -: 4]);
      slot(d[19 - 8*b -: 4]);
    end
    deselect();
  endtask

  // Read two bytes from a and compare the four nibbles, then the deselect.
  task automatic do_read(input logic [23:0] a, input logic [15:0] exp, input string nm);
    send_hdr(8'h03, a);
    slot(4'h0);
    slot(4'h0);
    for (int k = 0; k < 4; k++) begin
      check_out(nm, 1'b1, exp[15 - 4*k -: 4]);
      if (k < 3) slot(4'h0);
    end
    deselect();
    check_out({nm, "_deselect"}, 1'b0, 4'h0);
  endtask

  initial begin
    // Read of 0x000200 with sck=0 stalls in the address, dummy and read phases.
    tbl.push_back({1'b0, 1'b1, 4'h0, 4'h0, 1'b0});
    tbl.push_back({1'b0, 1'b1, 4'h3, 4'h0, 1'b0});
    tbl.push_back({1'b0, 1'b1, 4'h0, 4'h0, 1'b0});
    tbl.push_back({1'b0, 1'b1, 4'h0, 4'h0, 1'b0});
    tbl.push_back({1'b0, 1'b0, 4'hF, 4'h0, 1'b0});
    tbl.push_back({1'b0, 1'b1, 4'h0, 4'h0, 1'b0});
    tbl.push_back({1'b0, 1'b1, 4'h2, 4'h0, 1'b0});
    tbl.push_back({1'b0, 1'b1, 4'h0, 4'h0, 1'b0});
    tbl.push_back({1'b0, 1'b1, 4'h0, 4'h0, 1'b0});
    tbl.push_back({1'b0, 1'b1, 4'h0, 4'h0, 1'b0});
    tbl.push_back({1'b0, 1'b0, 4'h0, 4'h0, 1'b0});
    tbl.push_back({1'b0, 1'b1, 4'h0, 4'h7, 1'b1});
    tbl.push_back({1'b0, 1'b0, 4'h0, 4'h7, 1'b1});
    tbl.push_back({1'b0, 1'b1, 4'h0, 4'hE, 1'b1});
    tbl.push_back({1'b0, 1'b0, 4'h0, 4'hE, 1'b1});
    tbl.push_back({1'b0, 1'b0, 4'h0, 4'hE, 1'b1});
    tbl.push_back({1'b0, 1'b1, 4'h0, 4'h1, 1'b1});
    tbl.push_back({1'b0, 1'b0, 4'h0, 4'h1, 1'b1});
    tbl.push_back({1'b0, 1'b1, 4'h0, 4'h9, 1'b1});
    tbl.push_back({1'b0, 1'b1, 4'h0, 4'h4, 1'b1});
    tbl.push_back({1'b1, 1'b0, 4'h0, 4'h0, 1'b0});

    // Reset state.
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);
    check_out("reset_state", 1'b0, 4'h0);
    @(negedge gck);
    rst = 1'b0;

    // Reset asserted mid-address phase, then a fresh write.
    slot(4'h0);
    slot(4'h2);
    slot(4'h0);
    slot(4'h0);
    rst = 1'b1;
    #1;
    check_out("reset_mid_addr", 1'b0, 4'h0);
    @(negedge gck);
    rst = 1'b0;
    deselect();
    check_out("after_reset_idle", 1'b0, 4'h0);
    do_write(24'h000123, 24'hA5C300, 2);
    bd_check("write_0123", 17'h00123, 8'hA5);
    bd_check("write_0124", 17'h00124, 8'hC3);

    // Read-after-write across transfers.
    do_read(24'h000123, 16'hA5C3, "read_0123");

    // Plain read of backdoor-loaded data, then the stalled read table.
    bd_write(17'h00200, 8'h7E);
    bd_write(17'h00201, 8'h19);
    bd_write(17'h00202, 8'h4D);
    do_read(24'h000200, 16'h7E19, "read_0200");
    foreach (tbl[i]) begin
      cyc(tbl[i].cs, tbl[i].sck, tbl[i].sio);
      check_out($sformatf("tbl_%0d", i), tbl[i].exp_en, tbl[i].exp_sio);
    end

    // Wrap: upper address bits ignored, 0x1FFFF wraps to 0.
    do_write(24'hFFFFFF, 24'h112233, 3);
    bd_check("wrap_1ffff", 17'h1FFFF, 8'h11);
    bd_check("wrap_00000", 17'h00000, 8'h22);
    bd_check("wrap_00001", 17'h00001, 8'h33);
    do_read(24'h01FFFF, 16'h1122, "read_wrap");

    // Abort after one data nibble.
    bd_write(17'h00300, 8'h3C);
    send_hdr(8'h02, 24'h000300);
    slot(4'h9);
    deselect();
    bd_check("abort_0300", 17'h00300, 8'h3C);

    // Unsupported command 0x05 followed by write-looking traffic.
    bd_write(17'h00400, 8'h5A);
    slot(4'h0);
    slot(4'h5);
    for (int i = 0; i < 20; i++) begin
      slot((i < 4) ? 4'h0 : ((i == 3) ? 4'h4 : 4'hF));
      check_out("ignore_en", 1'b0, 4'h0);
    end
    deselect();
    bd_check("ignore_0400", 17'h00400, 8'h5A);
    bd_check("ignore_0000", 17'h00000, 8'h22);

    // Same-edge frontdoor/backdoor writes: same byte and different bytes.
    send_hdr(8'h02, 24'h000010);
    slot(4'hB);
    bd_wr    = 1'b1;
    bd_addr  = 17'h00010;
    bd_wdata = 8'h55;
    slot(4'h6);
    bd_wr = 1'b0;
    slot(4'h7);
    bd_wr    = 1'b1;
    bd_addr  = 17'h00020;
    bd_wdata = 8'h99;
    slot(4'hC);
    bd_wr = 1'b0;
    deselect();
    bd_check("collide_0010", 17'h00010, 8'hB6);
    bd_check("collide_0011", 17'h00011, 8'h7C);
    bd_check("collide_0020", 17'h00020, 8'h99);

    // Reset asserted mid-read drops the outputs at once; array survives.
    send_hdr(8'h03, 24'h000200);
    slot(4'h0);
    slot(4'h0);
    check_out("pre_reset_read", 1'b1, 4'h7);
    rst = 1'b1;
    #1;
    check_out("reset_mid_read", 1'b0, 4'h0);
    @(negedge gck);
    rst = 1'b0;
    deselect();
    do_read(24'h000200, 16'h7E19, "read_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/idli_sqi_mem_m.md
Name: idli_sqi_mem_m

Overview:
Synthesisable model of one SQI serial SRAM. Sits directly downstream of the core's lo/hi memory pins; the bench instantiates two, one per half. Consumes SCK/CS/SIO nibbles from the core and returns read data on SIO. Supports SQI READ/WRITE with sequential auto-increment, plus a backdoor port for bench preload and checking.

Parameters:
ADDR_W, 17, byte address width of the array (2^ADDR_W bytes); upper bits of the 24-bit SQI address are ignored.
DUMMY_NIBBLES, 2, dummy nibble slots between the address and read data.

Ports:
i_mem_gck  in  1  clock; all state is updated on the rising edge.
i_mem_rst  in  1  asynchronous active-high reset.
i_mem_sck  in  1  transfer enable: a gck edge with sck=1 and cs=0 is one nibble slot.
i_mem_cs   in  1  chip select, active low.
i_mem_sio  in  4  nibble from the core (slice_t).
o_mem_sio  out 4  nibble to the core (slice_t), registered.
o_mem_sio_en out 1  high while o_mem_sio carries read data.
i_mem_bd_wr  in  1  backdoor byte write strobe.
i_mem_bd_addr in ADDR_W  backdoor byte address (write and read).
i_mem_bd_wdata in 8  backdoor write data.
o_mem_bd_rdata out 8  combinational array read at i_mem_bd_addr.

Behaviour:
- Reset: state=IDLE, nibble counter=0, address=0, o_mem_sio=0, o_mem_sio_en=0. The array is not reset; contents survive reset.
- cs=1 at any edge forces IDLE, clears the counter and o_mem_sio_en, and aborts any transfer. A partially received write byte (one nibble) is discarded.
- A slot is an edge with cs=0 and sck=1. Edges with cs=0 and sck=0 hold all state.
- Nibbles are most-significant first throughout.
- States:
  - IDLE: on the first slot, capture the command high nibble -> CMD.
  - CMD: capture the low nibble. 0x03 -> ADDR (read). 0x02 -> ADDR (write). Any other value -> IGNORE.
  - ADDR: six slots shift in the 24-bit address; keep the low ADDR_W bits. After the sixth slot go to DUMMY (read) or WRITE (write).
  - DUMMY: DUMMY_NIBBLES slots; input ignored. o_mem_sio is loaded during the last dummy slot so that it is valid in the first READ slot. With DUMMY_NIBBLES=0, the last address slot performs this load.
  - READ: in each slot o_mem_sio holds the current nibble and o_mem_sio_en=1. Order is high nibble of byte[addr], then its low nibble, then addr+1. The register updates at the end of each slot for the next slot.
  - WRITE: first slot latches the high nibble; second slot writes the full byte to array[addr] and increments addr.
  - IGNORE: wait for cs=1; o_mem_sio=0, o_mem_sio_en=0.
- Address increment wraps 2^ADDR_W-1 -> 0 in both READ and WRITE.
- Read-after-write across transfers returns the new data. A READ slot sees backdoor writes made on earlier edges.
- Simultaneous frontdoor write and backdoor write to the same byte on the same edge: frontdoor wins. Different bytes: both complete.
- cs rising mid-read: o_mem_sio_en drops on that edge. o_mem_sio returns to 0.
- Reset asserted mid-transfer: immediate return to reset values. The next transfer requires a fresh cs=0 command.

Decomposition:
- Shared package (idli_pkg): SQI_CMD_READ=8'h03, SQI_CMD_WRITE=8'h02, SQI_ADDR_NIBBLES=6, and the enum sqi_state_t {IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE}. Reuse the existing slice_t.
- One natural sub-module: idli_sqi_ram_m. Byte array with one synchronous write port arbitrated frontdoor-over-backdoor, one asynchronous read port for the serialiser and one for the backdoor. The FSM, shifters and counter stay in idli_sqi_mem_m.

Test Plan:
- Reset then idle: assert rst mid-address-phase, release, hold cs=1 -> o_mem_sio=0, o_mem_sio_en=0, state IDLE; a fresh write succeeds.
- Write: cs=0; nibbles 0,2, addr 00,01,23, data A,5,C,3 -> bd_rdata @0x0123=0xA5, @0x0124=0xC3.
- Read: backdoor 0x0200=0x7E, 0x0201=0x19; nibbles 0,3, addr 000200, 2 dummy -> o_mem_sio sequence 7,E,1,9 with o_mem_sio_en=1 from slot 10.
- Wrap: ADDR_W=17, write 3 bytes starting at 0x1FFFF -> bytes land at 0x1FFFF, 0x00000, 0x00001.
- Abort and bad command: write one data nibble then cs=1 -> target byte unchanged. Command 0x05 -> o_mem_sio_en stays 0 for 20 slots and the array is unchanged.
- Stall and collision: toggle sck=0 between read slots -> same nibble sequence, stretched. Frontdoor and backdoor write to 0x10 on the same edge -> frontdoor value retained.
